serial_compare_ctrl: RTL and testbench
======================================

// Module: serial_compare_ctrl
// PURPOSE
//   Sequencer that compares two WIDTH-bit unsigned words using a 1-bit
//   compare slice, one bit per clock, MSB first.
//   Operands are captured on a start handshake and shifted out bit by bit.
//   The first differing bit decides greater/equal/less.
//   Sits between a requester and the 1-bit comparator datapath.
//   Returns a one-cycle done pulse with a held 3-bit result.
// PARAMETERS
//   WIDTH  8  operand width in bits (>=2)
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      request; sampled only while busy=0
//   a      in   WIDTH  operand A, unsigned, captured when start is accepted
//   b      in   WIDTH  operand B, unsigned, captured when start is accepted
//   busy   out  1      high from the accept edge until the done edge
//   done   out  1      one-cycle pulse; y is valid from this cycle onward
//   y      out  3      result {gt,eq,lt}: y[2]=A>B, y[1]=A==B, y[0]=A<B; one-hot when valid
// BEHAVIOUR
//   - Reset (async, any time, including mid-operation):
//     state=IDLE, busy=0, done=0, y=3'b000, shift regs and counter cleared.
//     An interrupted operation produces no done pulse.
//   - FSM states: IDLE and RUN. All outputs are registered.
//   - IDLE: start=1 at a clock edge (the accept edge E0) does the following:
//       - loads a and b into shift regs and sets cnt=WIDTH;
//       - clears the sticky decided flag and sets busy=1;
//       - moves to RUN.
//     y keeps its previous value until the next done.
//   - RUN, at each edge Ek (k=1..WIDTH):
//       - compare the MSBs of the shift regs, then shift both left 1 and do cnt-1;
//       - if decided=0 and the bits differ: set decided, record gt (a-bit=1) or lt.
//   - Completion edge:
//       - without early exit: edge EWIDTH;
//       - with early exit: see CONFIGURATION.
//     On that edge: y=recorded result (gt or lt), or 3'b010 if no bit differed;
//     done=1 for exactly one cycle; busy=0; state=IDLE.
//   - Latency: done is visible in the cycle after the completion edge.
//   - start while busy=1 is ignored. Operands are not re-sampled during RUN.
//   - Back-to-back: start=1 during the done cycle is accepted at the next
//     edge (busy=0 there). No bubble is required beyond the done cycle.
//   - Counter width is $clog2(WIDTH+1). cnt never wraps; RUN exits at cnt==1->0.
// CONFIGURATION
//   EARLY_EXIT_EN defined:
//     - completion occurs at the first differing bit: the edge that processes
//       bit i (MSB=WIDTH-1), i.e. E(WIDTH-i);
//     - equal operands still take WIDTH cycles.
//   EARLY_EXIT_EN undefined:
//     - always WIDTH cycles in RUN (fixed latency);
//     - the decided flag only freezes the result.
//   Result values are identical in both builds.
// TESTING (WIDTH=8; run all scenarios in both builds)
//   1. Reset: rst=1 for 2 cycles, then release
//      -> busy=0, done=0, y=000; no done pulse with start=0.
//   2. a=8'hA5, b=8'hA5, 1-cycle start
//      -> busy for 8 cycles; done 1 cycle after E8; y=010.
//   3. a=8'h80, b=8'h7F
//      -> y=100; done after E1 (EARLY_EXIT_EN) or after E8 (without).
//   4. a=8'h12, b=8'h13
//      -> y=001; done after E8 in both builds (bit 0 decides).
//   5. Busy and back-to-back handling:
//      - start held high while busy, with a/b changed to 8'hFF/8'h00
//        -> result still reflects the captured operands;
//      - start during the done cycle -> second op accepted next edge, correct y.
//   6. Reset during RUN: start a=8'h01, b=8'h02, assert rst after E4
//      -> busy=0, y=000 immediately; no done pulse;
//      -> a new start after release completes normally.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Compares two WIDTH-bit unsigned words one bit per clock, MSB first,
//   through a 1-bit compare slice. Operands are captured on an accepted
//   start, shifted out bit by bit, and the first differing bit decides the
//   result. A one-cycle done pulse accompanies a held one-hot result.
//
// Parameters
//   WIDTH  operand width in bits (>= 2)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   start  in   request, sampled only while busy=0
//   a, b   in   WIDTH-bit unsigned operands, captured on accept
//   busy   out  high from the accept edge until the completion edge
//   done   out  one-cycle pulse; y is valid from this cycle onward
//   y      out  {gt,eq,lt}, held until the next done
//
// Build option
//   EARLY_EXIT_EN  finish on the first differing bit instead of always
//                  spending WIDTH cycles; result values are identical.

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       y
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n, sb, sb_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             decided, decided_n;
  logic             rec_gt, rec_gt_n;
  logic             busy_n, done_n;
  logic [2:0]       y_n;

  logic bit_a, bit_b, diff, gt_now, finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      rec_gt  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= '0;
    end else begin
      state   <= state_n;
      sa      <= sa_n;
      sb      <= sb_n;
      cnt     <= cnt_n;
      decided <= decided_n;
      rec_gt  <= rec_gt_n;
      busy    <= busy_n;
      done    <= done_n;
      y       <= y_n;
    end
  end

  always_comb begin
    state_n   = state;
    sa_n      = sa;
    sb_n      = sb;
    cnt_n     = cnt;
    decided_n = decided;
    rec_gt_n  = rec_gt;
    busy_n    = busy;
    done_n    = 1'b0;
    y_n       = y;

    bit_a  = sa[WIDTH-1];
    bit_b  = sb[WIDTH-1];
    diff   = bit_a ^ bit_b;
    // Direction of the deciding bit: the recorded one if already decided,
    // otherwise the bit being examined on this edge.
    gt_now = decided ? rec_gt : bit_a;
    finish = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sa_n      = a;
          sb_n      = b;
          cnt_n     = CW'(WIDTH);
          decided_n = 1'b0;
          rec_gt_n  = 1'b0;
          busy_n    = 1'b1;
          state_n   = RUN;
        end
      end
      RUN: begin
        sa_n  = {sa[WIDTH-2:0], 1'b0};
        sb_n  = {sb[WIDTH-2:0], 1'b0};
        cnt_n = cnt - CW'(1);
        if (!decided && diff) begin
          decided_n = 1'b1;
          rec_gt_n  = bit_a;
        end
`ifdef EARLY_EXIT_EN
        finish = (cnt == CW'(1)) || (!decided && diff);
`else
        finish = (cnt == CW'(1));
`endif
        if (finish) begin
          // The current edge's bit counts toward the result.
          if (decided || diff)
            y_n = gt_now ? 3'b100 : 3'b001;
          else
            y_n = 3'b010;
          cnt_n   = '0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl (WIDTH=8). Works in both builds
// (EARLY_EXIT_EN defined or not). A transaction-level model predicts
// busy/done/y each cycle from unsigned comparison and first-difference
// latency; directed operations also check literal results and latencies.

module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [2:0]   y;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_y(input logic [W-1:0] x, input logic [W-1:0] z);
    if (x > z)       return 3'b100;
    else if (x == z) return 3'b010;
    else             return 3'b001;
  endfunction

  // Edges after the accept edge until completion.
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] z);
    int lat;
    logic [W-1:0] d;
    lat = W;
`ifdef EARLY_EXIT_EN
    d = x ^ z;
    for (int i = 0; i < W; i++)
      if (d[i]) lat = W - i;
`else
    d = '0;
    lat = W + int'(d);
`endif
    return lat;
  endfunction

  logic       m_busy, m_done;
  logic [2:0] m_y, m_pend;
  int         m_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_y    <= 3'b000;
      m_pend <= 3'b000;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_rem  <= ref_lat(a, b);
          m_pend <= ref_y(a, b);
        end
      end else if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_y    <= m_pend;
        m_rem  <= 0;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_busy", {7'd0, busy}, {7'd0, m_busy});
      check("cyc_done", {7'd0, done}, {7'd0, m_done});
      check("cyc_y",    {5'd0, y},    {5'd0, m_y});
    end
  end

  // ---------------- directed stimulus ----------------
  // Call at #1 after a posedge. Returns #1 after the completion edge
  // (inside the done cycle). hold=1 keeps start high while busy and
  // swaps the operands to FF/00 to show they are not re-sampled.
  task automatic do_op(input string name, input logic [W-1:0] opa, input logic [W-1:0] opb,
                       input logic [2:0] exp_y, input int exp_lat, input bit hold);
    int n;
    bit seen;
    start = 1'b1;
    a = opa;
    b = opb;
    @(posedge clk); #1;
    if (hold) begin
      a = 8'hFF;
      b = 8'h00;
    end else begin
      start = 1'b0;
    end
    check({name, "_busy_acc"}, {7'd0, busy}, 8'd1);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      total_cnt++;
      $display("FAIL %s_timeout: no done within %0d edges", name, n);
    end else begin
      check({name, "_lat"}, 8'(n), 8'(exp_lat));
      check({name, "_y"}, {5'd0, y}, {5'd0, exp_y});
      check({name, "_busy_done"}, {7'd0, busy}, 8'd0);
    end
  endtask

  initial begin
    start = 1'b0;
    a = '0;
    b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_y", {5'd0, y}, 8'd0);
    rst = 1'b0;
    // Idle with start low: no done pulse.
    repeat (4) @(posedge clk);
    #1;
    check("idle_done", {7'd0, done}, 8'd0);

    do_op("eq_a5", 8'hA5, 8'hA5, 3'b010, 8, 0);
    @(posedge clk); #1;
`ifdef EARLY_EXIT_EN
    do_op("gt_msb", 8'h80, 8'h7F, 3'b100, 1, 0);
`else
    do_op("gt_msb", 8'h80, 8'h7F, 3'b100, 8, 0);
`endif
    @(posedge clk); #1;
    do_op("lt_lsb", 8'h12, 8'h13, 3'b001, 8, 0);
    @(posedge clk); #1;
    do_op("hold", 8'h3C, 8'h3D, 3'b001, 8, 1);
    // Back-to-back: start issued inside the done cycle.
`ifdef EARLY_EXIT_EN
    do_op("b2b", 8'h40, 8'h10, 3'b100, 2, 0);
`else
    do_op("b2b", 8'h40, 8'h10, 3'b100, 8, 0);
`endif
    do_op("b2b2", 8'h00, 8'hFF, 3'b001, 1 + ((ref_lat(8'h00, 8'hFF) == 8) ? 7 : 0), 0);
    @(posedge clk); #1;

    // Reset during RUN, after E4.
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_y", {5'd0, y}, 8'd0);
    check("midrst_done", {7'd0, done}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_nodone", {7'd0, done}, 8'd0);
`ifdef EARLY_EXIT_EN
    do_op("after_rst", 8'h01, 8'h02, 3'b001, 7, 0);
`else
    do_op("after_rst", 8'h01, 8'h02, 3'b001, 8, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("final_y_held", {5'd0, y}, 8'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
